// File: rtl/sim_top_pkg.sv
// Shared definitions for the tone player: field widths and the note word layout.
package sim_top_pkg;

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned DUR_W  = 24;
  localparam int unsigned NOTE_W = 40;

  // Note word as sent by the MCU: half-period in clocks, then duration in ticks.
  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [DUR_W-1:0] dur;
  } note_t;

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles pwm every div clocks while enabled.
// Ports: clk, nreset (sync, active-high), enable (note playing), restart
// (clear counter and force pwm low), div (half-period in clocks), pwm (output).
module tone_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             enable,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             pwm
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             pwm_q, pwm_d;

  // Half-period counter; div==0 is a rest and holds pwm low.
  always_comb begin
    cnt_d = cnt_q;
    pwm_d = pwm_q;
    if (restart) begin
      cnt_d = '0;
      pwm_d = 1'b0;
    end else if (enable) begin
      if (div == '0) begin
        cnt_d = '0;
        pwm_d = 1'b0;
      end else if (cnt_q == div - DIV_W'(1)) begin
        cnt_d = '0;
        pwm_d = ~pwm_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/sim_top.sv
// Tone player top: captures a note word while ce is high, commits it on the
// falling edge of ce and plays it on pwm for dur*DUR_PRESCALE clocks.
// Ports: clk, nreset (sync, active-high), newFlattenedMCUout (note word),
// ce (frame strobe), pwm (square wave), maingMusic (note active).
// Optional build macro SIMTOP_NOTE_QUEUE_EN: one-entry pending note buffer
// instead of restarting on a commit during playback.
module sim_top #(
  parameter int unsigned DIV_W        = sim_top_pkg::DIV_W,
  parameter int unsigned DUR_W        = sim_top_pkg::DUR_W,
  parameter int unsigned DUR_PRESCALE = 1
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic [sim_top_pkg::NOTE_W-1:0] newFlattenedMCUout,
  input  logic                           ce,
  output logic                           pwm,
  output logic                           maingMusic
);

  import sim_top_pkg::*;

  localparam int unsigned PRE_W = (DUR_PRESCALE > 1) ? $clog2(DUR_PRESCALE) : 1;

  logic              ce_q, ce_d;
  logic [NOTE_W-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              active_q, active_d;

  logic [DIV_W-1:0]  sh_div_c;
  logic [DUR_W-1:0]  sh_dur_c;
  logic              commit_c;
  logic              pre_wrap_c;
  logic              expire_c;
  logic              restart_c;

`ifdef SIMTOP_NOTE_QUEUE_EN
  logic              pend_q, pend_d;
  logic [DIV_W-1:0]  pend_div_q, pend_div_d;
  logic [DUR_W-1:0]  pend_dur_q, pend_dur_d;
`endif

  // Decode the shadow word and detect commit / expiry events.
  always_comb begin
    sh_div_c   = shadow_q[NOTE_W-1 -: DIV_W];
    sh_dur_c   = shadow_q[DUR_W-1:0];
    commit_c   = ce_q & ~ce & (sh_dur_c != '0);
    pre_wrap_c = (pre_q == PRE_W'(DUR_PRESCALE - 1));
    expire_c   = active_q & pre_wrap_c & (dur_q == DUR_W'(1));
  end

  // Next-state for capture, duration countdown and note loading.
  always_comb begin
    ce_d      = ce;
    shadow_d  = ce ? newFlattenedMCUout : shadow_q;
    div_d     = div_q;
    dur_d     = dur_q;
    pre_d     = pre_q;
    active_d  = active_q;
    restart_c = 1'b0;
`ifdef SIMTOP_NOTE_QUEUE_EN
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    pend_dur_d = pend_dur_q;
`endif

    if (active_q) begin
      pre_d = pre_wrap_c ? '0 : pre_q + PRE_W'(1);
      if (pre_wrap_c) begin
        dur_d = dur_q - DUR_W'(1);
      end
    end

`ifdef SIMTOP_NOTE_QUEUE_EN
    if (expire_c) begin
      restart_c = 1'b1;
      if (pend_q) begin
        div_d    = pend_div_q;
        dur_d    = pend_dur_q;
        pre_d    = '0;
        active_d = 1'b1;
        pend_d   = commit_c;
        if (commit_c) begin
          pend_div_d = sh_div_c;
          pend_dur_d = sh_dur_c;
        end
      end else if (commit_c) begin
        div_d    = sh_div_c;
        dur_d    = sh_dur_c;
        pre_d    = '0;
        active_d = 1'b1;
      end else begin
        active_d = 1'b0;
      end
    end else if (commit_c) begin
      if (active_q) begin
        // Current note keeps playing; a later commit overwrites this one.
        pend_d     = 1'b1;
        pend_div_d = sh_div_c;
        pend_dur_d = sh_dur_c;
      end else begin
        div_d     = sh_div_c;
        dur_d     = sh_dur_c;
        pre_d     = '0;
        active_d  = 1'b1;
        restart_c = 1'b1;
      end
    end
`else
    // A commit always wins, including over a same-cycle expiry.
    if (commit_c) begin
      div_d     = sh_div_c;
      dur_d     = sh_dur_c;
      pre_d     = '0;
      active_d  = 1'b1;
      restart_c = 1'b1;
    end else if (expire_c) begin
      active_d  = 1'b0;
      restart_c = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      ce_q     <= 1'b0;
      shadow_q <= '0;
      div_q    <= '0;
      dur_q    <= '0;
      pre_q    <= '0;
      active_q <= 1'b0;
    end else begin
      ce_q     <= ce_d;
      shadow_q <= shadow_d;
      div_q    <= div_d;
      dur_q    <= dur_d;
      pre_q    <= pre_d;
      active_q <= active_d;
    end
  end

`ifdef SIMTOP_NOTE_QUEUE_EN
  always_ff @(posedge clk) begin
    if (nreset) begin
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      pend_dur_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      pend_dur_q <= pend_dur_d;
    end
  end
`endif

  tone_gen #(
    .DIV_W (DIV_W)
  ) u_tone_gen (
    .clk     (clk),
    .nreset  (nreset),
    .enable  (active_q),
    .restart (restart_c),
    .div     (div_q),
    .pwm     (pwm)
  );

  assign maingMusic = active_q;

endmodule

// File: tb/tb_sim_top.sv
// Directed bench for sim_top: expected {maingMusic, pwm} per cycle are derived
// from each note's div/dur, queued at stimulus time and popped each cycle.
module tb_sim_top;

  import sim_top_pkg::*;

  logic              clk = 1'b0;
  logic              nreset;
  logic              ce;
  logic [NOTE_W-1:0] word;
  logic              pwm;
  logic              maingMusic;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic mm;
    logic pwm;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sim_top dut (
    .clk                (clk),
    .nreset             (nreset),
    .newFlattenedMCUout (word),
    .ce                 (ce),
    .pwm                (pwm),
    .maingMusic         (maingMusic)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed {mm,pwm}=%b expected=%b at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Sample k after the commit edge: high for k<dur, pwm = floor(k/div) parity.
  task automatic push_note(input logic [15:0] div, input int unsigned dur, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      exp_t e;
      e.mm  = (k < dur);
      e.pwm = ((k < dur) && (div != 16'd0)) ? 1'((k / 32'(div)) & 32'd1) : 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(tag, {maingMusic, pwm}, e);
      if (sb.size() > 0) tick();
    end
  endtask

  // Hold ce for 'hold' cycles (earlier words random, last one w), then drop it.
  task automatic commit(input logic [NOTE_W-1:0] w, input int unsigned hold);
    ce = 1'b1;
    for (int unsigned i = 0; i < hold; i++) begin
      word = (i == hold - 1) ? w : NOTE_W'({$urandom(), $urandom()});
      tick();
    end
    ce = 1'b0;
    tick();
  endtask

  initial begin
    nreset = 1'b1;
    ce     = 1'b0;
    word   = '0;
    repeat (5) tick();
    chk("reset", {maingMusic, pwm}, 2'b00);

    nreset = 1'b0;
    tick();
    push_note(16'd0, 0, 20);
    drain("idle_after_reset");

    commit(40'h0003000010, 1);
    push_note(16'd3, 16, 20);
    drain("basic_note");

    commit(40'h0005000000, 1);
    push_note(16'd0, 0, 10);
    drain("dur_zero");

    commit(40'h0000000004, 1);
    push_note(16'd0, 4, 8);
    drain("rest_note");

    commit(40'h42B46D8012, 7);
    push_note(16'd17076, 7176210, 52000);
    drain("long_note");

    commit(40'h0002000008, 1);
    push_note(16'd2, 8, 12);
    drain("restart_mid_note");

    commit(40'h0003000010, 1);
    push_note(16'd3, 16, 5);
    drain("pre_reset_note");

    nreset = 1'b1;
    tick();
    chk("reset_mid_note", {maingMusic, pwm}, 2'b00);

    ce   = 1'b1;
    word = 40'h0001000005;
    tick();
    tick();
    nreset = 1'b0;
    ce     = 1'b0;
    tick();
    push_note(16'd0, 0, 10);
    drain("ce_across_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
